ysyx_ifu: RTL

Instruction fetch unit: the producer end of the instruction/PC interface that the decode stage consumes. Holds the fetch PC, issues one word request at a time to instruction memory over a valid/ready request plus valid-only response bus, and presents the fetched instruction with its PC to decode under a valid/ready handshake. Accepts jump redirects from execute and discards any in-flight fetch made obsolete by a redirect.

---
 rtl/ysyx_pkg.sv | 5 +
 rtl/ysyx_pc_reg.sv | 16 +
 rtl/ysyx_ifu.sv | 70 +++++++
 3 files changed

// File: rtl/ysyx_pkg.sv
// ysyx_pkg: shared types and constants for the fetch stage
package ysyx_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} ifu_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
endpackage

// File: rtl/ysyx_pc_reg.sv
// ysyx_pc_reg: fetch PC register with word-aligned redirect load and +4 step
module ysyx_pc_reg import ysyx_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= load_pc & ~32'h3;
    else if (inc) pc <= pc + 32'd4;
endmodule

// File: rtl/ysyx_ifu.sv
// ysyx_ifu: single-outstanding instruction fetch with redirect and stale-response kill
module ysyx_ifu import ysyx_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  ifu_state_t state, state_n;
  logic kill, kill_n, capture, inc;
  logic [31:0] fetch_pc, inst_q, pc_q;
  ysyx_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(redirect_valid), .load_pc(redirect_pc), .inc(inc), .pc(fetch_pc)
  );
  always_comb begin
    state_n = state;
    kill_n = kill;
    capture = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        state_n = mem_req_ready ? WAIT : REQ;
        kill_n = kill | (mem_req_ready & redirect_valid);
      end
      WAIT: begin
        if (mem_resp_valid) begin
          // a response for a superseded address is dropped and refetched
          capture = !kill && !redirect_valid;
          state_n = capture ? VALID : REQ;
          kill_n = 1'b0;
        end else kill_n = kill | redirect_valid;
      end
      VALID: begin
        inc = inst_ready && !redirect_valid;
        state_n = (inst_ready || redirect_valid) ? REQ : VALID;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      kill <= 1'b0;
      inst_q <= '0;
      pc_q <= '0;
    end else begin
      state <= state_n;
      kill <= kill_n;
      if (capture) begin
        inst_q <= mem_resp_data;
        pc_q <= fetch_pc;
      end
    end
  assign mem_req_valid = state == REQ;
  assign inst_valid = state == VALID;
  assign mem_req_addr = fetch_pc;
  assign inst = inst_q;
  assign pc = pc_q;
endmodule
